// File: rtl/parking_apb_slave_if.sv
// APB bus bundle between the bus interface (master) and the parking register block (slave).
`timescale 1ns/1ps
interface parking_apb_slave_if;
  logic [1:0] paddr;
  logic       pwrite;
  logic       psel;
  logic       penable;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;

  modport master (
    output paddr, pwrite, psel, penable, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, pwrite, psel, penable, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/parking_apb_slave.sv
// Parking access controller register block: APB slave, occupancy counter,
// entry/exit arbitration and a timed entry-barrier pulse.
`timescale 1ns/1ps
module parking_apb_slave #(
  parameter int         WAIT_STATES = 0,
  parameter logic [7:0] DEF_CAP     = 8'd50,
  parameter int         GATE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  parking_apb_slave_if.slave apb,
  input  logic              entry_req,
  input  logic              exit_req,
  output logic              gate_open,
  output logic              full
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} apb_state_t;
  typedef enum logic {CLOSED, OPEN} gate_state_t;

  apb_state_t  apb_state, apb_next;
  gate_state_t gate_state, gate_next;

  logic [2:0]  ws_cnt;
  logic        commit;
  logic        enable;
  logic [7:0]  capacity;
  logic [7:0]  count;
  logic        ev_denied;
  logic        ev_underflow;
  logic [15:0] gate_timer;
  logic [7:0]  prdata_q;
  logic        pready_q;
  logic        pslverr_q;
  logic [7:0]  rdata;

  logic wr_commit, rd_commit, wr_ctrl, wr_cap, bad_wr, rd_events, clr_cnt;
  logic accept, exit_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) apb_state <= IDLE;
    else       apb_state <= apb_next;
  end

  // commit marks the edge that ends the transfer: side effects and the registered response happen together.
  always_comb begin
    apb_next = apb_state;
    commit   = 1'b0;
    case (apb_state)
      IDLE: begin
        if (apb.psel && !apb.penable) apb_next = SETUP;
      end
      SETUP: begin
        if (!apb.psel) begin
          apb_next = IDLE;
        end else if (apb.penable) begin
          if (WAIT_STATES == 0) begin
            apb_next = DONE;
            commit   = 1'b1;
          end else begin
            apb_next = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (!apb.psel) begin
          apb_next = IDLE;
        end else if (ws_cnt == 3'd0) begin
          apb_next = DONE;
          commit   = 1'b1;
        end
      end
      DONE:    apb_next = IDLE;
      default: apb_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                     ws_cnt <= 3'd0;
    else if (apb_state == SETUP)                   ws_cnt <= 3'(WAIT_STATES - 1);
    else if (apb_state == ACCESS && ws_cnt != 3'd0) ws_cnt <= ws_cnt - 3'd1;
  end

  assign wr_commit = commit && apb.pwrite;
  assign rd_commit = commit && !apb.pwrite;
  assign wr_ctrl   = wr_commit && (apb.paddr == 2'd0);
  assign wr_cap    = wr_commit && (apb.paddr == 2'd1);
  assign bad_wr    = wr_commit && apb.paddr[1];
  assign rd_events = rd_commit && (apb.paddr == 2'd3);
  assign clr_cnt   = wr_ctrl && apb.pwdata[1];

  // Acceptance is judged on the registered COUNT/CAPACITY, before this edge's updates.
  assign accept  = entry_req && enable && (count < capacity) && (count != 8'hFF);
  assign exit_ok = exit_req && (count != 8'd0);
  assign full    = (count >= capacity);

  always_comb begin
    rdata = 8'd0;
    case (apb.paddr)
      2'd0:    rdata = {7'd0, enable};
      2'd1:    rdata = capacity;
      2'd2:    rdata = count;
      2'd3:    rdata = {5'd0, full, ev_underflow, ev_denied};
      default: rdata = 8'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable   <= 1'b0;
      capacity <= DEF_CAP;
    end else begin
      if (wr_ctrl) enable   <= apb.pwdata[0];
      if (wr_cap)  capacity <= apb.pwdata;
    end
  end

  // A clear request overrides any same-cycle entry or exit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   count <= 8'd0;
    else if (clr_cnt)            count <= 8'd0;
    else if (accept && !exit_ok) count <= count + 8'd1;
    else if (exit_ok && !accept) count <= count - 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ev_denied    <= 1'b0;
      ev_underflow <= 1'b0;
    end else begin
      ev_denied    <= (ev_denied    && !rd_events) || (entry_req && !accept);
      ev_underflow <= (ev_underflow && !rd_events) || (exit_req && (count == 8'd0));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pready_q  <= 1'b0;
      prdata_q  <= 8'd0;
      pslverr_q <= 1'b0;
    end else begin
      pready_q  <= commit;
      prdata_q  <= rd_commit ? rdata : 8'd0;
      pslverr_q <= bad_wr;
    end
  end

  assign apb.pready  = pready_q;
  assign apb.prdata  = prdata_q;
  assign apb.pslverr = pslverr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) gate_state <= CLOSED;
    else       gate_state <= gate_next;
  end

  always_comb begin
    gate_next = gate_state;
    case (gate_state)
      CLOSED:  if (accept) gate_next = OPEN;
      OPEN:    if (!accept && gate_timer == 16'd0) gate_next = CLOSED;
      default: gate_next = CLOSED;
    endcase
  end

  // Timer holds the remaining open cycles after the current one; every accepted entry reloads it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                        gate_timer <= 16'd0;
    else if (accept)                                  gate_timer <= 16'(GATE_CYCLES - 1);
    else if (gate_state == OPEN && gate_timer != 16'd0) gate_timer <= gate_timer - 16'd1;
  end

  assign gate_open = (gate_state == OPEN);

endmodule
